// File: rtl/multi_channel_toggle_ctrl_pkg.sv
// Shared types and helpers for multi_channel_toggle_ctrl.
// Optional feature macro (used by the top level): TOGGLE_EDGE_DETECT_EN.
package multi_channel_toggle_ctrl_pkg;

    // Per-channel FSM states.
    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } chan_state_e;

    // Bits needed to hold values 0..n-1, never less than 1.
    // Used for the mode width (n = MODES) and the hold-off counter (n = HOLDOFF).
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Default hold-off length and the counter width derived from it.
    localparam int unsigned DEFAULT_HOLDOFF = 16;
    localparam int unsigned DEFAULT_CNT_W   = width_of(DEFAULT_HOLDOFF);

endpackage

// File: rtl/multi_channel_toggle_ctrl_toggle_channel.sv
// One channel: mode register, hold-off counter and IDLE/HOLD FSM.
module toggle_channel
    import multi_channel_toggle_ctrl_pkg::*;
#(
    parameter int unsigned MODES   = 2,
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned MW      = width_of(MODES)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pulse,
    input  logic          clear,
    input  logic          freeze,
    output logic [MW-1:0] mode,
    output logic          changed,
    output logic          busy
);

    localparam int unsigned    CW        = width_of(HOLDOFF);
    localparam logic [MW-1:0]  MODE_MAX  = MW'(MODES - 1);
    localparam logic [CW-1:0]  CNT_INIT  = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [MW-1:0] mode_q, mode_d;
    logic          changed_q, changed_d;
    logic          busy_q, busy_d;

    // Next-state: accept/ignore pulses, run hold-off, then let clear override mode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        changed_d = 1'b0;
        busy_d    = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pulse && !freeze && !clear) begin
                    mode_d    = (mode_q == MODE_MAX) ? '0 : mode_q + MW'(1);
                    changed_d = 1'b1;
                    if (HOLDOFF > 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_INIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Clear only touches the mode; an in-progress hold-off keeps running.
        if (clear) begin
            mode_d    = '0;
            changed_d = (mode_q != '0);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    assign mode    = mode_q;
    assign changed = changed_q;
    assign busy    = busy_q;

endmodule

// File: rtl/multi_channel_toggle_ctrl.sv
// CHANNELS independent modulo-MODES toggle registers with per-channel hold-off.
// Optional macro TOGGLE_EDGE_DETECT_EN: treat pulse as a level and act on rising edges only.
module multi_channel_toggle_ctrl
    import multi_channel_toggle_ctrl_pkg::*;
#(
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned MODES    = 2,
    parameter  int unsigned HOLDOFF  = 16,
    localparam int unsigned MW       = width_of(MODES)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    pulse,
    input  logic [CHANNELS-1:0]    clear,
    input  logic                   freeze,
    output logic [CHANNELS*MW-1:0] mode,
    output logic [CHANNELS-1:0]    active,
    output logic [CHANNELS-1:0]    changed,
    output logic [CHANNELS-1:0]    busy
);

    logic [CHANNELS-1:0] pulse_eff;

`ifdef TOGGLE_EDGE_DETECT_EN
    logic [CHANNELS-1:0] pulse_prev_q, pulse_prev_d;
    logic [CHANNELS-1:0] pulse_edge_q, pulse_edge_d;

    // Rising-edge detect on the pulse level; the edge itself is registered.
    always_comb begin
        pulse_prev_d = pulse;
        pulse_edge_d = pulse & ~pulse_prev_q;
    end

    // Edge-detect registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            pulse_prev_q <= '0;
            pulse_edge_q <= '0;
        end else begin
            pulse_prev_q <= pulse_prev_d;
            pulse_edge_q <= pulse_edge_d;
        end
    end

    assign pulse_eff = pulse_edge_q;
`else
    assign pulse_eff = pulse;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        toggle_channel #(
            .MODES   (MODES),
            .HOLDOFF (HOLDOFF),
            .MW      (MW)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .pulse   (pulse_eff[i]),
            .clear   (clear[i]),
            .freeze  (freeze),
            .mode    (mode[i*MW +: MW]),
            .changed (changed[i]),
            .busy    (busy[i])
        );

        assign active[i] = (mode[i*MW +: MW] != '0);
    end

endmodule

// File: doc/multi_channel_toggle_ctrl.md
Name: multi_channel_toggle_ctrl

Overview:
Parametrised successor to the single pause-toggle bit. It holds CHANNELS independent mode registers, and each one advances modulo MODES on an accepted pulse. A per-channel hold-off window rejects pulse bursts from bouncy buttons. Per-channel clear and a global freeze are provided. It sits between the button/pulse generators and the draw/display logic, which consume mode, active and changed.

Parameters:
CHANNELS, 4, number of independent channels (>=1)
MODES, 2, states per channel (>=2); MODES=2 gives plain toggle behaviour
HOLDOFF, 16, cycles after an accepted pulse during which further pulses on that channel are ignored (0 = no hold-off)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pulse  in  CHANNELS  per-channel advance strobe
clear  in  CHANNELS  per-channel synchronous return to mode 0
freeze  in  1  global: when high, pulses are ignored (not queued)
mode  out  CHANNELS*MW  packed per-channel mode, MW = clog2(MODES); channel i occupies bits [i*MW +: MW]
active  out  CHANNELS  per-channel (mode != 0)
changed  out  CHANNELS  one-cycle strobe: mode of that channel updated on the previous edge
busy  out  CHANNELS  channel is in hold-off

Behaviour:
- Interface: one clock, clock. Reset is synchronous and active-high on reset; the polarity and synchronicity are fixed.
- Reset (sampled high on an edge): all mode=0, active=0, changed=0, busy=0, and all hold-off counters=0. Reset overrides every other input. Reset mid-hold-off aborts the window.
- Per-channel FSM, states IDLE and HOLD.
  - IDLE, accepted pulse (pulse[i]=1, freeze=0, clear[i]=0):
    - mode <= (mode==MODES-1) ? 0 : mode+1
    - changed[i] <= 1 for exactly one cycle
    - if HOLDOFF>0: go to HOLD, cnt <= HOLDOFF-1, busy[i] <= 1; otherwise stay in IDLE
  - HOLD: pulse[i] is ignored. cnt decrements each cycle. When cnt==0, go to IDLE and busy[i] <= 0 on that edge. busy is therefore high for exactly HOLDOFF cycles.
- Latency: pulse sampled at edge N gives mode and changed updated after edge N. A new pulse is accepted no earlier than edge N+HOLDOFF+1.
- clear[i]: mode <= 0. changed[i] pulses only if mode was nonzero. Hold-off state is untouched.
- clear[i] and pulse[i] in the same cycle: clear wins, the pulse is discarded, and no hold-off starts.
- freeze=1: pulses are dropped, not queued. Hold-off counters keep running. clear still acts.
- A pulse held high continuously for many cycles is accepted once every HOLDOFF+1 cycles.
- active is derived combinationally from registered mode. changed is registered.
- Channels are fully independent; simultaneous pulses on several channels all act in the same cycle.

Optional Feature:
Macro: TOGGLE_EDGE_DETECT_EN.
- Defined: pulse is treated as a level. An internal register detects rising edges, and only a 0->1 transition counts as a pulse, adding 1 cycle of latency. The edge register resets to 0.
- Undefined: pulse is a strobe, and every high cycle counts as a pulse (subject to hold-off and freeze).

Decomposition:
- Shared package: MW width function (clog2), FSM state enum {ST_IDLE, ST_HOLD}, hold-off counter width constant derived from HOLDOFF.
- Sub-module toggle_channel: one channel's FSM, counter and mode register, instantiated CHANNELS times in a generate loop. The top level handles only packing and the optional edge detect.

Test Plan:
- Default params; reset high for 2 cycles, then single-cycle pulse[0] -> mode0=1, changed[0]=1 for one cycle, busy[0] high exactly 16 cycles, other channels stay 0.
- MODES=3: three pulses on ch2, spaced 20 cycles apart -> mode2 goes 1, 2, 0 (wrap), active[2]=1, 1, 0.
- Second pulse[1] 5 cycles after the first (within hold-off) -> ignored, mode1 stays 1. Pulse at +17 cycles -> mode1=0.
- pulse[3] and clear[3] in the same cycle with mode3=1 -> mode3=0, changed[3]=1, busy[3]=0. With freeze=1, pulse[3] -> no change.
- pulse[0] held high 40 cycles, HOLDOFF=16, macro undefined -> 3 acceptances (cycles 0, 17, 34). Macro defined -> exactly 1 acceptance.
- Reset asserted at cycle 5 of hold-off -> busy=0 next cycle, mode=0, and a pulse 1 cycle after reset release is accepted.
